// File: rtl/cr_axi4s_mst.sv
// AXI4-Stream master: push-side FIFO feeding a registered output holding stage.
// Optional beat/frame statistics counters are enabled by defining CR_AXI4S_MST_STATS_EN.
package cr_axi4s_mst_pkg;
  typedef struct packed {
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;
endpackage

module cr_axi4s_mst
  import cr_axi4s_mst_pkg::*;
#(
  parameter int unsigned N_ENTRIES   = 16,
  parameter int unsigned N_AFULL_VAL = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          axi4s_mst_wr,
  input  axi4s_dp_bus_t axi4s_mst_in,
  output logic          axi4s_mst_full,
  output logic          axi4s_mst_afull,
  output logic          axi4s_mst_ovfl,
  output axi4s_dp_bus_t axi4s_ob_out,
  input  axi4s_dp_rdy_t axi4s_ob_in,
  output logic          axi4s_mst_in_frame,
  output logic [31:0]   axi4s_mst_beat_cnt,
  output logic [15:0]   axi4s_mst_frame_cnt
);
  localparam int unsigned AW = $clog2(N_ENTRIES);

  typedef enum logic {EMPTY, VALID} state_t;

  axi4s_dp_bus_t mem [N_ENTRIES];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  state_t        state;
  axi4s_dp_bus_t ob_q;
  logic          fifo_ne, push, pop, hs;

  assign fifo_ne         = occ != '0;
  assign axi4s_mst_full  = occ == (AW+1)'(N_ENTRIES);
  assign axi4s_mst_afull = occ >= (AW+1)'(N_ENTRIES - N_AFULL_VAL);
  assign push            = axi4s_mst_wr & ~axi4s_mst_full;
  assign hs              = (state == VALID) & axi4s_ob_in.tready;
  // Refill the holding register whenever it is empty or being drained this cycle.
  assign pop             = fifo_ne & ((state == EMPTY) | axi4s_ob_in.tready);
  assign axi4s_ob_out    = ob_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= axi4s_mst_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      occ            <= '0;
      axi4s_mst_ovfl <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
      if (axi4s_mst_wr & axi4s_mst_full) axi4s_mst_ovfl <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= EMPTY;
      ob_q               <= '0;
      axi4s_mst_in_frame <= 1'b0;
    end else begin
      if (hs) axi4s_mst_in_frame <= ~ob_q.tlast;
      case (state)
        EMPTY: begin
          if (fifo_ne) begin
            ob_q        <= mem[rd_ptr];
            ob_q.tvalid <= 1'b1;
            state       <= VALID;
          end
        end
        VALID: begin
          if (axi4s_ob_in.tready) begin
            if (fifo_ne) begin
              ob_q        <= mem[rd_ptr];
              ob_q.tvalid <= 1'b1;
            end else begin
              ob_q.tvalid <= 1'b0;
              state       <= EMPTY;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef CR_AXI4S_MST_STATS_EN
  logic [31:0] beat_cnt_q;
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else if (hs) begin
      beat_cnt_q <= beat_cnt_q + 32'd1;
      if (ob_q.tlast) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign axi4s_mst_beat_cnt  = beat_cnt_q;
  assign axi4s_mst_frame_cnt = frame_cnt_q;
`else
  assign axi4s_mst_beat_cnt  = '0;
  assign axi4s_mst_frame_cnt = '0;
`endif
endmodule

// File: tb/tb_cr_axi4s_mst.sv
// Randomized self-checking bench for cr_axi4s_mst against a queue-based stream model.
module tb_cr_axi4s_mst;
  import cr_axi4s_mst_pkg::*;

  localparam int N  = 16;
  localparam int AF = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr = 1'b0;
  axi4s_dp_bus_t din = '0;
  axi4s_dp_bus_t dout;
  axi4s_dp_rdy_t rdy = '0;
  logic          full, afull, ovfl, in_frame;
  logic [31:0]   beat_cnt;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  cr_axi4s_mst #(.N_ENTRIES(N), .N_AFULL_VAL(AF)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .axi4s_mst_wr        (wr),
    .axi4s_mst_in        (din),
    .axi4s_mst_full      (full),
    .axi4s_mst_afull     (afull),
    .axi4s_mst_ovfl      (ovfl),
    .axi4s_ob_out        (dout),
    .axi4s_ob_in         (rdy),
    .axi4s_mst_in_frame  (in_frame),
    .axi4s_mst_beat_cnt  (beat_cnt),
    .axi4s_mst_frame_cnt (frame_cnt)
  );

  // Model: every buffered beat in push order; head is on the bus when m_valid.
  axi4s_dp_bus_t exp_q[$];
  bit            m_valid, m_ovfl, m_inf, hs_seen;
  int            m_fifo;
  logic [31:0]   m_beat;
  logic [15:0]   m_frame;
  axi4s_dp_bus_t hs_beat;
  int            nvec = 0;
  int            nerr = 0;

  function automatic void model_reset();
    exp_q.delete();
    m_valid = 0; m_ovfl = 0; m_inf = 0; m_fifo = 0; m_beat = '0; m_frame = '0;
  endfunction

  function automatic axi4s_dp_bus_t rand_beat();
    axi4s_dp_bus_t b;
    b.tvalid = 1'($urandom);
    b.tdata  = $urandom;
    b.tkeep  = 4'($urandom);
    b.tlast  = 1'($urandom);
    return b;
  endfunction

  function automatic logic [89:0] mdl_vec();
    logic [36:0] pay = '0;
    logic [31:0] eb  = '0;
    logic [15:0] ef  = '0;
    if (m_valid) pay = {exp_q[0].tdata, exp_q[0].tkeep, exp_q[0].tlast};
`ifdef CR_AXI4S_MST_STATS_EN
    eb = m_beat;
    ef = m_frame;
`endif
    return {m_valid, pay, m_fifo == N, m_fifo >= N - AF, m_ovfl, m_inf, eb, ef};
  endfunction

  function automatic logic [89:0] obs_vec();
    logic [36:0] pay = '0;
    if (dout.tvalid) pay = {dout.tdata, dout.tkeep, dout.tlast};
    return {dout.tvalid, pay, full, afull, ovfl, in_frame, beat_cnt, frame_cnt};
  endfunction

  // Advance one clock with the inputs currently driven and update the model.
  task automatic tick();
    bit full_m, push, pop, drop;
    axi4s_dp_bus_t b;
    full_m  = (m_fifo == N);
    hs_seen = m_valid && rdy.tready;
    push    = wr && !full_m;
    drop    = wr && full_m;
    pop     = (m_fifo > 0) && (!m_valid || rdy.tready);
    b       = din;
    b.tvalid = 1'b1;
    @(posedge clk);
    #1;
    if (hs_seen) begin
      hs_beat = exp_q.pop_front();
      m_inf   = !hs_beat.tlast;
      m_beat  = m_beat + 32'd1;
      if (hs_beat.tlast) m_frame = m_frame + 16'd1;
    end
    if (push) exp_q.push_back(b);
    if (drop) m_ovfl = 1;
    m_fifo  = m_fifo + int'(push) - int'(pop);
    m_valid = pop ? 1'b1 : (hs_seen ? 1'b0 : m_valid);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    nvec++;
    if ({dout, full, afull, ovfl, in_frame, beat_cnt, frame_cnt} !== '0) begin
      nerr++;
      $display("FAIL reset: got %h want 0", {dout, full, afull, ovfl, in_frame, beat_cnt, frame_cnt});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [15:0] ef;
`ifdef CR_AXI4S_MST_STATS_EN
    ef = 16'd1;
`else
    ef = 16'd0;
`endif
    rdy.tready = 1'b1;
    wr = 1'b1;
    din = '{tvalid: 1'b0, tdata: 32'hA5, tkeep: 4'hF, tlast: 1'b1};
    tick();
    wr = 1'b0;
    nvec++;
    if (dout.tvalid !== 1'b0) begin nerr++; $display("FAIL single_lat1: tvalid %b want 0", dout.tvalid); end
    tick();
    nvec++;
    if ({dout.tvalid, dout.tdata} !== {1'b1, 32'hA5}) begin
      nerr++; $display("FAIL single_lat2: tvalid %b tdata %h want 1 a5", dout.tvalid, dout.tdata);
    end
    tick();
    nvec++;
    if ({frame_cnt, in_frame, dout.tvalid} !== {ef, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL single_done: frame_cnt %h in_frame %b tvalid %b want %h 0 0", frame_cnt, in_frame, dout.tvalid, ef);
    end
  endtask

  task automatic test_stream16();
    int cnt = 0, first = -1, last = -1;
    rdy.tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr  = (i < 16);
      din = rand_beat();
      tick();
      nvec++;
      if (obs_vec() !== mdl_vec()) begin nerr++; $display("FAIL stream cyc %0d: got %h want %h", i, obs_vec(), mdl_vec()); end
      if (dout.tvalid) begin cnt++; last = i; if (first < 0) first = i; end
    end
    wr = 1'b0;
    nvec++;
    if (cnt != 16 || last - first + 1 != 16) begin
      nerr++; $display("FAIL stream_contig: %0d valid cycles over span %0d want 16", cnt, last - first + 1);
    end
  endtask

  task automatic test_fill();
    axi4s_dp_bus_t held = '0;
    rdy.tready = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      wr  = 1'b1;
      din = rand_beat();
      tick();
      nvec++;
      if (obs_vec() !== mdl_vec()) begin nerr++; $display("FAIL fill push %0d: got %h want %h", i, obs_vec(), mdl_vec()); end
      if (i == 2) held = dout;
      if (i > 2) begin
        nvec++;
        if (dout !== held) begin nerr++; $display("FAIL fill_hold %0d: got %h want %h", i, dout, held); end
      end
      if (i == 15 || i == 16 || i == 17 || i == 18) begin
        logic [2:0] want;
        want = (i == 15) ? 3'b000 : (i == 16) ? 3'b100 : (i == 17) ? 3'b110 : 3'b111;
        nvec++;
        if ({afull, full, ovfl} !== want) begin
          nerr++; $display("FAIL fill_flags %0d: afull/full/ovfl %b want %b", i, {afull, full, ovfl}, want);
        end
      end
    end
    wr = 1'b0;
    rdy.tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      nvec++;
      if (obs_vec() !== mdl_vec()) begin nerr++; $display("FAIL drain cyc %0d: got %h want %h", i, obs_vec(), mdl_vec()); end
    end
  endtask

  task automatic test_toggle();
    int k = 0;
    for (int i = 0; i < 14; i++) begin
      wr  = (i < 4);
      din = rand_beat();
      din.tlast = (i == 3);
      rdy.tready = (i % 2 == 1);
      tick();
      nvec++;
      if (obs_vec() !== mdl_vec()) begin nerr++; $display("FAIL toggle cyc %0d: got %h want %h", i, obs_vec(), mdl_vec()); end
      if (hs_seen) begin
        k++;
        nvec++;
        if (in_frame !== (k < 4)) begin nerr++; $display("FAIL toggle_frame beat %0d: in_frame %b want %b", k, in_frame, k < 4); end
      end
    end
    wr = 1'b0;
    nvec++;
    if (k != 4) begin nerr++; $display("FAIL toggle_count: %0d handshakes want 4", k); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 440; i++) begin
      wr  = (i < 400) && ($urandom_range(0, 9) < 6);
      din = rand_beat();
      rdy.tready = (i >= 400) || ($urandom_range(0, 9) < 5);
      tick();
      nvec++;
      if (obs_vec() !== mdl_vec()) begin nerr++; $display("FAIL random cyc %0d: got %h want %h", i, obs_vec(), mdl_vec()); end
    end
    wr = 1'b0;
  endtask

  task automatic test_reset_mid();
    rdy.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr  = 1'b1;
      din = rand_beat();
      din.tlast = 1'b0;
      tick();
    end
    wr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if ({dout, full, afull, ovfl, in_frame, beat_cnt, frame_cnt} !== '0) begin
      nerr++;
      $display("FAIL reset_mid: got %h want 0", {dout, full, afull, ovfl, in_frame, beat_cnt, frame_cnt});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rdy.tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      nvec++;
      if (dout.tvalid !== 1'b0 || obs_vec() !== mdl_vec()) begin
        nerr++; $display("FAIL post_reset cyc %0d: got %h want %h", i, obs_vec(), mdl_vec());
      end
    end
  endtask

`ifdef CR_AXI4S_MST_STATS_EN
  task automatic test_wrap();
    int k = 0;
    force dut.beat_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.beat_cnt_q;
    m_beat = 32'hFFFF_FFFF;
    rdy.tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr  = (i < 2);
      din = rand_beat();
      tick();
      if (hs_seen) begin
        k++;
        nvec++;
        if (beat_cnt !== 32'(k - 1)) begin nerr++; $display("FAIL wrap beat %0d: beat_cnt %h want %h", k, beat_cnt, 32'(k - 1)); end
      end
    end
    wr = 1'b0;
    nvec++;
    if (k != 2) begin nerr++; $display("FAIL wrap_count: %0d handshakes want 2", k); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stream16();
    test_fill();
    test_toggle();
    test_random();
    test_reset_mid();
`ifdef CR_AXI4S_MST_STATS_EN
    test_wrap();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/cr_axi4s_mst.md
CR_AXI4S_MST -- requirements
Module: cr_axi4s_mst

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 16, internal FIFO depth in beats; legal values are powers of two, 4 to 256.
REQ-002 SHALL have parameter N_AFULL_VAL, default 1, so that afull asserts when occupancy >= N_ENTRIES - N_AFULL_VAL.
REQ-003 SHALL have port clk, input, 1 bit, rising-edge clock for all logic.
REQ-004 SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 SHALL have port axi4s_mst_wr, input, 1 bit, producer push strobe.
REQ-006 SHALL have port axi4s_mst_in, input, axi4s_dp_bus_t, producer beat; its tvalid field is ignored.
REQ-007 SHALL have port axi4s_mst_full, output, 1 bit, FIFO full.
REQ-008 SHALL have port axi4s_mst_afull, output, 1 bit, FIFO almost full.
REQ-009 SHALL have port axi4s_mst_ovfl, output, 1 bit, sticky overflow error.
REQ-010 SHALL have port axi4s_ob_out, output, axi4s_dp_bus_t, AXI4-Stream master beat.
REQ-011 SHALL have port axi4s_ob_in, input, axi4s_dp_rdy_t, downstream tready.
REQ-012 SHALL have port axi4s_mst_in_frame, output, 1 bit, high while a frame is partially transmitted.
REQ-013 SHALL have port axi4s_mst_beat_cnt, output, 32 bits, transmitted beat count.
REQ-014 SHALL have port axi4s_mst_frame_cnt, output, 16 bits, transmitted frame count (beats with tlast).

Function
REQ-015 SHALL accept a push when axi4s_mst_wr=1 and full=0; the beat is written into the FIFO on that clock edge.
REQ-016 SHALL drop a push with full=1, leave FIFO contents unchanged, and set axi4s_mst_ovfl=1 until reset.
REQ-017 SHALL drive full and afull from registered occupancy only; a push and a pop in the same cycle leave occupancy unchanged.
REQ-018 SHALL contain an output holding register with states EMPTY (tvalid=0) and VALID (tvalid=1).
REQ-019 In EMPTY with FIFO non-empty, the block SHALL pop one beat, load the register, and go to VALID on the next edge.
REQ-020 In VALID with tready=1 and FIFO non-empty, the block SHALL pop and reload, giving back-to-back beats at 1 beat/cycle.
REQ-021 In VALID with tready=1 and FIFO empty, the block SHALL go to EMPTY.
REQ-022 In VALID with tready=0, the block SHALL hold every field of axi4s_ob_out stable and keep tvalid=1.
REQ-023 SHALL have a minimum latency of 2 cycles: a push at edge N reaches the FIFO, the register loads at edge N+1, and tvalid=1 is visible after edge N+1.
REQ-024 SHALL never deassert tvalid without a completed handshake (tvalid & tready).
REQ-025 SHALL NOT let tvalid depend combinationally on tready.
REQ-026 axi4s_mst_in_frame SHALL go to 1 on a handshake with tlast=0 and to 0 on a handshake with tlast=1; a single-beat frame leaves it 0.
REQ-027 SHALL transmit beats in push order, unmodified except for tvalid.
REQ-028 Occupancy SHALL count the FIFO only, so up to N_ENTRIES+1 beats can be buffered including the holding register.

Reset
REQ-029 On rst_n=0 the block SHALL immediately set to 0: tvalid and all other axi4s_ob_out fields, full, afull, ovfl, in_frame, both counters, and both FIFO pointers.
REQ-030 Reset mid-frame SHALL discard all buffered beats; after reset no partial frame is resumed.

Configuration
REQ-031 With macro CR_AXI4S_MST_STATS_EN defined, beat_cnt SHALL increment on every handshake and frame_cnt on every handshake with tlast=1.
REQ-032 Both counters SHALL wrap modulo 2^width.
REQ-033 With CR_AXI4S_MST_STATS_EN undefined, both counter outputs SHALL be constant 0 and no counter flops SHALL be inferred.

Verification
REQ-034 SHALL cover: push 1 beat (tlast=1, tdata=0xA5) into idle block -> tvalid=1 two cycles later, tdata=0xA5, frame_cnt=1 after handshake.
REQ-035 SHALL cover: tready=1 constantly, 16 consecutive pushes -> 16 contiguous tvalid cycles in order, beat_cnt=16.
REQ-036 SHALL cover: tready=0, push 17 beats with N_ENTRIES=16 -> full=1 after the 17th beat, afull=1 at FIFO occupancy 15, axi4s_ob_out unchanged while stalled, ovfl=0; an 18th push -> ovfl=1.
REQ-037 SHALL cover: toggle tready each cycle during a 4-beat frame -> each beat held until accepted, in_frame=1 after beat 1 and 0 after beat 4.
REQ-038 SHALL cover: assert rst_n=0 mid-frame with 5 beats buffered -> all outputs 0 asynchronously, no beats emitted after release.
REQ-039 SHALL cover: with STATS_EN, preload beat_cnt near 0xFFFFFFFF, send 2 beats -> beat_cnt wraps to 0x00000000 then 0x00000001.
